// File: rtl/exa_crosb_net_hdr_gen.sv
// Header generator: fills routing, type, size, address and path fields into a
// 128-bit template and holds the result in a single valid/ready output stage.
module exa_crosb_net_hdr_gen #(
  parameter string DEBUG     = "false",
  parameter int    CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [127:0]         i_hdr_base,
  input  logic [13:0]          i_dst_coord,
  input  logic [21:0]          i_src_coord,
  input  logic [4:0]           i_pkt_type,
  input  logic [13:0]          i_pkt_size,
  input  logic [41:0]          i_dst_addr,
  input  logic                 i_multipath_enable,
  input  logic [3:0]           i_path_mask,
  output logic [127:0]         o_header,
  output logic                 o_hdr_valid,
  input  logic                 i_hdr_ready,
  output logic                 o_prio,
  output logic                 o_enc_error,
  output logic [CNT_WIDTH-1:0] o_hdr_count
);

  // Handshake: a request moves when i_req_valid & o_req_ready; the held header
  // moves when o_hdr_valid & i_hdr_ready. Both may happen in the same cycle.

  logic                 hdr_valid_q, hdr_valid_d;
  logic [127:0]         header_q, header_d;
  logic                 prio_q, prio_d;
  logic                 enc_err_q, enc_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           rr_q, rr_d;

  logic        accept, out_hs;
  logic [3:0]  dst_x, dst_y, dst_z, src_x, src_y;
  logic [1:0]  dst_off;
  logic        remote, addr_err, coord_err, req_err, path_en;
  logic [2:0]  path_sel;
  logic [1:0]  rr_next, cand;
  logic        found;
  logic [127:0] hdr_build;
  logic [13:0] src_unused;

  assign dst_x   = i_dst_coord[3:0];
  assign dst_y   = i_dst_coord[7:4];
  assign dst_z   = i_dst_coord[11:8];
  assign dst_off = i_dst_coord[13:12];
  assign src_x   = i_src_coord[3:0];
  assign src_y   = i_src_coord[7:4];
  // Local z/off and the upper source bits play no part in routing decisions.
  assign src_unused = {i_src_coord[21:14], i_src_coord[13:8]};

  assign o_req_ready = ~hdr_valid_q | i_hdr_ready;
  assign accept      = i_req_valid & o_req_ready;
  assign out_hs      = hdr_valid_q & i_hdr_ready;

  assign remote    = (dst_x != src_x) | (dst_y != src_y);
  assign addr_err  = (i_pkt_type >= 5'd10) & (i_dst_addr[41:10] != {3'b111, 29'b0});
  assign coord_err = remote & (dst_x > 4'd3) & (dst_y == src_y);
  assign req_err   = addr_err | coord_err;
  assign path_en   = i_multipath_enable & remote & (|i_path_mask);

  // Round-robin search starting at rr; the pointer moves past the winner.
  always_comb begin
    path_sel = 3'd0;
    rr_next  = rr_q;
    found    = 1'b0;
    cand     = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (path_en && !found && i_path_mask[cand]) begin
        found    = 1'b1;
        path_sel = {1'b0, cand} + 3'd1;
        rr_next  = cand + 2'd1;
      end
    end
  end

  always_comb begin
    hdr_build          = i_hdr_base;
    hdr_build[20:16]   = i_pkt_type;
    hdr_build[24:21]   = dst_x;
    hdr_build[28:25]   = dst_y;
    hdr_build[32:29]   = dst_z;
    hdr_build[34:33]   = dst_off;
    hdr_build[48:35]   = i_pkt_size;
    // Small-address types carry only the low 10 bits; the rest stays template.
    if (i_pkt_type >= 5'd10) begin
      hdr_build[71:62] = i_dst_addr[9:0];
    end else begin
      hdr_build[103:62] = i_dst_addr;
    end
    hdr_build[111:109] = path_sel;
  end

  always_comb begin
    hdr_valid_d = hdr_valid_q;
    header_d    = header_q;
    prio_d      = prio_q;
    enc_err_d   = enc_err_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    if (out_hs) begin
      hdr_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_WIDTH'(1);
    end
    if (accept) begin
      if (req_err) begin
        enc_err_d   = 1'b1;
        hdr_valid_d = 1'b0;
      end else begin
        hdr_valid_d = 1'b1;
        header_d    = hdr_build;
        prio_d      = (i_pkt_type > 5'd16);
        rr_d        = rr_next;
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      hdr_valid_q <= 1'b0;
      header_q    <= '0;
      prio_q      <= 1'b0;
      enc_err_q   <= 1'b0;
      cnt_q       <= '0;
      rr_q        <= 2'd0;
    end else begin
      hdr_valid_q <= hdr_valid_d;
      header_q    <= header_d;
      prio_q      <= prio_d;
      enc_err_q   <= enc_err_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
    end
  end

  assign o_hdr_valid = hdr_valid_q;
  assign o_header    = header_q;
  assign o_prio      = prio_q;
  assign o_enc_error = enc_err_q;
  assign o_hdr_count = cnt_q;

  generate
    if (DEBUG == "true") begin : g_debug
      (* keep = "true", mark_debug = "true" *) logic [4:0] dbg_unused_taps;
      assign dbg_unused_taps = {addr_err, coord_err, path_sel};
    end
  endgenerate

endmodule

// File: tb/tb_exa_crosb_net_hdr_gen.sv
// Bench for exa_crosb_net_hdr_gen: directed scenarios plus random traffic
// against a cycle-level behavioural model with an expected-header queue.
module tb_exa_crosb_net_hdr_gen;

  localparam int CNT_WIDTH = 16;
  localparam logic [41:0] SMALL_BASE = {3'b111, 39'b0};

  logic                 Clk = 1'b0;
  logic                 Resetn;
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [127:0]         i_hdr_base;
  logic [13:0]          i_dst_coord;
  logic [21:0]          i_src_coord;
  logic [4:0]           i_pkt_type;
  logic [13:0]          i_pkt_size;
  logic [41:0]          i_dst_addr;
  logic                 i_multipath_enable;
  logic [3:0]           i_path_mask;
  logic [127:0]         o_header;
  logic                 o_hdr_valid;
  logic                 i_hdr_ready;
  logic                 o_prio;
  logic                 o_enc_error;
  logic [CNT_WIDTH-1:0] o_hdr_count;

  always #5 Clk = ~Clk;

  exa_crosb_net_hdr_gen #(.DEBUG("false"), .CNT_WIDTH(CNT_WIDTH)) dut (
    .Clk(Clk), .Resetn(Resetn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_hdr_base(i_hdr_base), .i_dst_coord(i_dst_coord), .i_src_coord(i_src_coord),
    .i_pkt_type(i_pkt_type), .i_pkt_size(i_pkt_size), .i_dst_addr(i_dst_addr),
    .i_multipath_enable(i_multipath_enable), .i_path_mask(i_path_mask),
    .o_header(o_header), .o_hdr_valid(o_hdr_valid), .i_hdr_ready(i_hdr_ready),
    .o_prio(o_prio), .o_enc_error(o_enc_error), .o_hdr_count(o_hdr_count)
  );

  int total = 0;
  int bad   = 0;

  // Model state: {prio, header} of the held header sits at exp_q[0].
  logic [128:0] exp_q[$];
  bit           m_valid;
  bit           m_err;
  int           m_rr;
  int           m_count;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err();
    bit is_remote;
    is_remote = (i_dst_coord[3:0] != i_src_coord[3:0]) || (i_dst_coord[7:4] != i_src_coord[7:4]);
    if (i_pkt_type >= 10 && (i_dst_addr >> 10) != 42'hE000_0000) return 1'b1;
    if (is_remote && i_dst_coord[3:0] > 3 && i_dst_coord[7:4] == i_src_coord[7:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_path();
    bit is_remote;
    is_remote = (i_dst_coord[3:0] != i_src_coord[3:0]) || (i_dst_coord[7:4] != i_src_coord[7:4]);
    if (!i_multipath_enable || !is_remote || i_path_mask == 4'd0) return 0;
    for (int s = 0; s < 4; s++) begin
      if (i_path_mask[(m_rr + s) % 4]) return ((m_rr + s) % 4) + 1;
    end
    return 0;
  endfunction

  function automatic logic [127:0] model_hdr(input int p);
    logic [127:0] h;
    h = i_hdr_base;
    h[20:16]   = i_pkt_type;
    h[24:21]   = i_dst_coord[3:0];
    h[28:25]   = i_dst_coord[7:4];
    h[32:29]   = i_dst_coord[11:8];
    h[34:33]   = i_dst_coord[13:12];
    h[48:35]   = i_pkt_size;
    if (i_pkt_type >= 10) h[71:62] = i_dst_addr[9:0];
    else                  h[103:62] = i_dst_addr;
    h[111:109] = 3'(p);
    return h;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_rr    = 0;
    m_count = 0;
  endtask

  task automatic post_check();
    check("hdr_valid", 128'(o_hdr_valid), 128'(m_valid));
    check("enc_error", 128'(o_enc_error), 128'(m_err));
    check("hdr_count", 128'(o_hdr_count), 128'(m_count));
    if (m_valid) begin
      check("held_header", o_header, exp_q[0][127:0]);
      check("held_prio", 128'(o_prio), 128'(exp_q[0][128]));
    end
  endtask

  // One clock: inputs were set at the preceding falling edge.
  task automatic cycle();
    bit rdy, hs, acc;
    int p;
    logic [128:0] e;
    #1;
    rdy = !m_valid || i_hdr_ready;
    hs  = m_valid && i_hdr_ready;
    acc = i_req_valid && rdy;
    check("req_ready", 128'(o_req_ready), 128'(rdy));
    if (hs) begin
      e = exp_q.pop_front();
      check("hs_header", o_header, e[127:0]);
      m_count = (m_count + 1) % (1 << CNT_WIDTH);
      m_valid = 1'b0;
    end
    if (acc) begin
      if (model_err()) begin
        m_err   = 1'b1;
        m_valid = 1'b0;
      end else begin
        p = model_path();
        exp_q.push_back({(i_pkt_type > 16), model_hdr(p)});
        m_valid = 1'b1;
        if (p != 0) m_rr = p % 4;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    post_check();
  endtask

  task automatic set_req(input logic v, input logic [3:0] dx, input logic [3:0] dy,
                         input logic [3:0] lx, input logic [3:0] ly, input logic [1:0] off,
                         input logic [4:0] typ, input logic [41:0] addr,
                         input logic mp, input logic [3:0] mask);
    i_req_valid        = v;
    i_dst_coord        = {off, 4'($urandom_range(0, 15)), dy, dx};
    i_src_coord        = {14'($urandom), ly, lx};
    i_pkt_type         = typ;
    i_pkt_size         = 14'($urandom);
    i_dst_addr         = addr;
    i_multipath_enable = mp;
    i_path_mask        = mask;
    i_hdr_base         = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    set_req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 5'd0, 42'd0, 1'b0, 4'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(o_hdr_valid), 128'(0));
    check({tag, "_header"}, o_header, 128'(0));
    check({tag, "_prio"}, 128'(o_prio), 128'(0));
    check({tag, "_err"}, 128'(o_enc_error), 128'(0));
    check({tag, "_count"}, 128'(o_hdr_count), 128'(0));
  endtask

  task automatic do_reset();
    Resetn      = 1'b0;
    i_hdr_ready = 1'b0;
    idle();
    model_reset();
    #3;
    check_reset_outputs("reset");
    check("reset_ready", 128'(o_req_ready), 128'(1));
    @(negedge Clk);
    Resetn = 1'b1;
  endtask

  int exp_paths[4] = '{2, 4, 2, 4};
  logic [63:0] r64;

  initial begin
    do_reset();

    // Local destination: path 0, offset carried, pointer untouched.
    set_req(1'b1, 4'd1, 4'd2, 4'd1, 4'd2, 2'd3, 5'd5, 42'h123_4567_89AB, 1'b1, 4'hF);
    cycle();
    check("local_valid", 128'(o_hdr_valid), 128'(1));
    check("local_path", 128'(o_header[111:109]), 128'(0));
    check("local_off", 128'(o_header[34:33]), 128'(3));
    i_hdr_ready = 1'b1;
    set_req(1'b1, 4'd2, 4'd2, 4'd1, 4'd2, 2'd0, 5'd3, 42'h0AA_0000_0000, 1'b1, 4'hF);
    cycle();
    check("rr_after_local", 128'(o_header[111:109]), 128'(1));
    idle();
    cycle();

    // Round-robin over mask 1010 from a fresh pointer.
    do_reset();
    i_hdr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 4'd3, 4'd2, 4'd1, 4'd2, 2'd1, 5'd2, 42'($urandom), 1'b1, 4'b1010);
      cycle();
      check("rr_path", 128'(o_header[111:109]), 128'(exp_paths[i]));
    end
    idle();
    cycle();
    check("rr_count", 128'(o_hdr_count), 128'(4));

    // Small address, then address error during an output handshake.
    do_reset();
    i_hdr_ready = 1'b1;
    set_req(1'b1, 4'd3, 4'd2, 4'd1, 4'd2, 2'd0, 5'd12, SMALL_BASE | 42'h155, 1'b1, 4'b1010);
    cycle();
    check("small_addr", 128'(o_header[71:62]), 128'h155);
    check("small_path", 128'(o_header[111:109]), 128'(2));
    set_req(1'b1, 4'd3, 4'd2, 4'd1, 4'd2, 2'd0, 5'd12, SMALL_BASE | 42'h10_0155, 1'b1, 4'b1010);
    cycle();
    check("addr_err_valid", 128'(o_hdr_valid), 128'(0));
    check("addr_err_flag", 128'(o_enc_error), 128'(1));
    set_req(1'b1, 4'd3, 4'd2, 4'd1, 4'd2, 2'd0, 5'd3, 42'($urandom), 1'b1, 4'b1010);
    cycle();
    check("rr_kept_on_err", 128'(o_header[111:109]), 128'(4));
    // Coordinate error: remote in x only with x beyond 3.
    set_req(1'b1, 4'd5, 4'd2, 4'd1, 4'd2, 2'd0, 5'd3, 42'($urandom), 1'b1, 4'hF);
    cycle();
    check("coord_err_valid", 128'(o_hdr_valid), 128'(0));
    set_req(1'b1, 4'd5, 4'd3, 4'd1, 4'd2, 2'd0, 5'd3, 42'($urandom), 1'b1, 4'hF);
    cycle();
    check("x_big_y_diff_ok", 128'(o_hdr_valid), 128'(1));
    idle();
    cycle();

    // Backpressure for five cycles, then simultaneous unload and load.
    do_reset();
    set_req(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 2'd2, 5'd4, 42'($urandom), 1'b0, 4'd0);
    cycle();
    set_req(1'b1, 4'd2, 4'd1, 4'd1, 4'd1, 2'd1, 5'd7, 42'($urandom), 1'b1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready_low", 128'(o_req_ready), 128'(0));
    end
    check("bp_count", 128'(o_hdr_count), 128'(0));
    i_hdr_ready = 1'b1;
    cycle();
    check("bp_release_count", 128'(o_hdr_count), 128'(1));
    check("bp_release_valid", 128'(o_hdr_valid), 128'(1));
    check("bp_new_type", 128'(o_header[20:16]), 128'(7));
    idle();
    cycle();

    // Priority threshold and counter wrap.
    do_reset();
    i_hdr_ready = 1'b1;
    set_req(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 2'd0, 5'd17, SMALL_BASE, 1'b0, 4'd0);
    cycle();
    check("prio_17", 128'(o_prio), 128'(1));
    set_req(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 2'd0, 5'd16, SMALL_BASE, 1'b0, 4'd0);
    cycle();
    check("prio_16", 128'(o_prio), 128'(0));
    for (int i = 0; i < (1 << CNT_WIDTH) - 2; i++) begin
      set_req(1'b1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'd1, 4'd1, 2'd0,
              5'($urandom_range(0, 9)), 42'($urandom), 1'b1, 4'($urandom));
      cycle();
    end
    check("count_all_ones", 128'(o_hdr_count), 128'(16'hFFFF));
    idle();
    cycle();
    check("count_wrap", 128'(o_hdr_count), 128'(0));

    // Asynchronous reset while a header is held.
    i_hdr_ready = 1'b0;
    set_req(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 2'd0, 5'd20, SMALL_BASE, 1'b0, 4'd0);
    cycle();
    check("pre_async_valid", 128'(o_hdr_valid), 128'(1));
    @(posedge Clk);
    #2;
    Resetn = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    idle();
    @(negedge Clk);
    Resetn = 1'b1;
    i_hdr_ready = 1'b1;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom, $urandom};
      set_req(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 2)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 2'($urandom),
              5'($urandom), ($urandom_range(0, 3) != 0) ? (SMALL_BASE | 42'(r64[9:0])) : r64[41:0],
              1'($urandom_range(0, 3) != 0), 4'($urandom));
      i_hdr_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
